// File: rtl/rotate_arbiter_if.sv
// Request, shifter and response signals for rotate_arbiter.
// slave is the arbiter's view. master is the view of the requesters, the shifter and the consumer.
interface rotate_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_data;
  logic [1:0] req0_amt;
  logic       req0_dir;

  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_data;
  logic [1:0] req1_amt;
  logic       req1_dir;

  logic [3:0] rot_w;
  logic       rot_s0;
  logic       rot_s1;
  logic [3:0] rot_y;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_id;

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    input  rot_y, rsp_ready,
    output req0_ready, req1_ready,
    output rot_w, rot_s0, rot_s1,
    output rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    output req1_valid, req1_data, req1_amt, req1_dir,
    output rot_y, rsp_ready,
    input  req0_ready, req1_ready,
    input  rot_w, rot_s0, rot_s1,
    input  rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter that shares one external rotate-right shifter between two requesters.
// One request is in flight at a time: IDLE accepts it, ISSUE drives the shifter, RESP returns the result.
module rotate_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  rotate_arbiter_if.slave    bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic             id_q, id_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             any_valid;
  logic             grant_id;
  logic [1:0]       grant_amt;
  logic             grant_dir;

  // With both requesters pending, the one that was not granted last time wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : ~bus.req0_valid;
    grant_amt = grant_id ? bus.req1_amt : bus.req0_amt;
    grant_dir = grant_id ? bus.req1_dir : bus.req0_dir;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    data_d         = data_q;
    sel_d          = sel_q;
    id_d           = id_q;
    rsp_data_d     = rsp_data_q;
    rsp_id_d       = rsp_id_q;
    op_count_d     = op_count_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rot_w      = 4'd0;
    bus.rot_s0     = 1'b0;
    bus.rot_s1     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          last_grant_d   = grant_id;
          id_d           = grant_id;
          data_d         = grant_id ? bus.req1_data : bus.req0_data;
          // A left rotate by n is the same as a right rotate by (4 - n) mod 4.
          sel_d          = grant_dir ? 2'(2'd0 - grant_amt) : grant_amt;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        bus.rot_w  = data_q;
        bus.rot_s0 = sel_q[0];
        bus.rot_s1 = sel_q[1];
        rsp_data_d = bus.rot_y;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_data_q   <= 4'd0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  // NOTE: the captured request is left out of reset on purpose. It is only observed in ISSUE,
  // and ISSUE is always entered through a fresh capture.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    sel_q  <= sel_d;
    id_q   <= id_d;
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter. It models the external shifter and predicts every grant
// and result with a transaction-level reference model.
module tb_rotate_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] op_count;

  rotate_arbiter_if bus ();

  rotate_arbiter #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // External shifter: y[i] = w[(i + sel) mod 4].
  logic [3:0] shifter_y;
  logic [1:0] shifter_idx;
  always_comb begin
    shifter_y   = 4'd0;
    shifter_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      shifter_idx  = 2'(i) + {bus.rot_s1, bus.rot_s0};
      shifter_y[i] = bus.rot_w[shifter_idx];
    end
  end
  assign bus.rot_y = shifter_y;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_last;
  int m_count;

  // Expected result, taken straight from the rotate direction rather than from a select value.
  function automatic logic [3:0] expect_rot(input logic [3:0] w, input logic [1:0] amt, input logic dir);
    logic [7:0] ww;
    ww = {w, w};
    if (dir) begin
      ww = ww << amt;
      return ww[7:4];
    end
    ww = ww >> amt;
    return ww[3:0];
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = 4'd0; bus.req0_amt = 2'd0; bus.req0_dir = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 4'd0; bus.req1_amt = 2'd0; bus.req1_dir = 1'b0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    m_last  = 1'b1;
    m_count = 0;
  endtask

  // One complete operation: offer requests, follow the grant through ISSUE and RESP, stall, handshake.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [3:0] d0, input logic [3:0] d1,
                        input logic [1:0] a0, input logic [1:0] a1,
                        input logic r0, input logic r1, input int stall,
                        output bit got_id, output logic [3:0] got_data);
    bit         exp_id;
    logic [3:0] exp_w, exp_y;
    logic [1:0] ea, exp_sel;
    logic       ed;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_amt = a0; bus.req0_dir = r0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_amt = a1; bus.req1_dir = r1;
    bus.rsp_ready  = 1'b0;
    #1;
    exp_id  = (v0 && v1) ? ~m_last : !v0;
    exp_w   = exp_id ? d1 : d0;
    ea      = exp_id ? a1 : a0;
    ed      = exp_id ? r1 : r0;
    exp_sel = ed ? 2'((4 - int'(ea)) % 4) : ea;
    exp_y   = expect_rot(exp_w, ea, ed);
    n_tests++;
    if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL grant: ready{1,0}=%b expected %b", {bus.req1_ready, bus.req0_ready},
               (exp_id ? 2'b10 : 2'b01));
    end
    m_last = exp_id;

    @(negedge clk);
    if (exp_id) bus.req1_valid = 1'b0;
    else        bus.req0_valid = 1'b0;
    #1;
    n_tests++;
    if ({busy, bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL issue_ctl: busy,rsp_valid,ready1,ready0=%b expected 1000",
               {busy, bus.rsp_valid, bus.req1_ready, bus.req0_ready});
    end
    n_tests++;
    if ({bus.rot_w, bus.rot_s1, bus.rot_s0} !== {exp_w, exp_sel}) begin
      n_fail++;
      $display("FAIL issue_drive: rot_w=%b sel=%0d expected rot_w=%b sel=%0d",
               bus.rot_w, {bus.rot_s1, bus.rot_s0}, exp_w, exp_sel);
    end

    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, exp_id, exp_y}) begin
      n_fail++;
      $display("FAIL rsp: valid=%b id=%b data=%b expected valid=1 id=%b data=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_id, exp_y);
    end
    n_tests++;
    if (op_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL count_before: op_count=%0d expected %0d", op_count, 8'(m_count));
    end
    got_id   = bus.rsp_id;
    got_data = bus.rsp_data;

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req1_ready, bus.req0_ready,
           bus.rot_w, bus.rot_s1, bus.rot_s0} !== {1'b1, exp_id, exp_y, 2'b00, 4'd0, 2'b00}
          || op_count !== 8'(m_count)) begin
        n_fail++;
        $display("FAIL stall: valid=%b id=%b data=%b ready=%b rot_w=%b count=%0d expected 1 %b %b 00 0000 %0d",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, {bus.req1_ready, bus.req0_ready},
                 bus.rot_w, op_count, exp_id, exp_y, 8'(m_count));
      end
    end
    bus.rsp_ready = 1'b1;

    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    m_count++;
    #1;
    n_tests++;
    if ({busy, bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 4'b0000 || op_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL handshake: busy,valid,ready=%b count=%0d expected 0000 %0d",
               {busy, bus.rsp_valid, bus.req1_ready, bus.req0_ready}, op_count, 8'(m_count));
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if ({busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, op_count} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b id=%b data=%b count=%0d expected all 0",
               busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data, op_count);
    end
    n_tests++;
    if ({bus.rot_w, bus.rot_s1, bus.rot_s0, bus.req1_ready, bus.req0_ready} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drive: rot_w=%b sel=%b ready=%b expected 0",
               bus.rot_w, {bus.rot_s1, bus.rot_s0}, {bus.req1_ready, bus.req0_ready});
    end
  endtask

  task automatic test_directed();
    bit         id;
    logic [3:0] d;
    apply_reset();
    run_op(1'b1, 1'b0, 4'b1000, 4'd0, 2'd1, 2'd0, 1'b0, 1'b0, 0, id, d);
    n_tests++;
    if ({id, d} !== {1'b0, 4'b0100} || op_count !== 8'd1) begin
      n_fail++;
      $display("FAIL dir_right1: id=%b data=%b count=%0d expected 0 0100 1", id, d, op_count);
    end
    run_op(1'b0, 1'b1, 4'd0, 4'b1000, 2'd0, 2'd1, 1'b0, 1'b1, 0, id, d);
    n_tests++;
    if ({id, d} !== {1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL dir_left1: id=%b data=%b expected 1 0001", id, d);
    end
    run_op(1'b1, 1'b0, 4'b1011, 4'd0, 2'd2, 2'd0, 1'b0, 1'b0, 0, id, d);
    n_tests++;
    if (d !== 4'b1110) begin
      n_fail++;
      $display("FAIL dir_right2: data=%b expected 1110", d);
    end
    run_op(1'b1, 1'b0, 4'b0110, 4'd0, 2'd0, 2'd0, 1'b1, 1'b0, 0, id, d);
    n_tests++;
    if (d !== 4'b0110) begin
      n_fail++;
      $display("FAIL dir_left0: data=%b expected 0110", d);
    end
    run_op(1'b0, 1'b1, 4'd0, 4'b0011, 2'd0, 2'd2, 1'b0, 1'b1, 0, id, d);
    n_tests++;
    if (d !== 4'b1100) begin
      n_fail++;
      $display("FAIL dir_left2: data=%b expected 1100", d);
    end
  endtask

  task automatic test_round_robin();
    bit         id;
    logic [3:0] d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 0, id, d);
      n_tests++;
      if (id !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL rr_order: op %0d granted %b expected %b", i, id, 1'(i % 2));
      end
    end
  endtask

  task automatic test_backpressure();
    bit         id;
    logic [3:0] d;
    run_op(1'b1, 1'b1, 4'b1001, 4'b0110, 2'd3, 2'd1, 1'b0, 1'b1, 5, id, d);
  endtask

  task automatic test_reset_abort();
    bit         id;
    logic [3:0] d;
    run_op(1'b1, 1'b0, 4'b0101, 4'd0, 2'd1, 2'd0, 1'b0, 1'b0, 0, id, d);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1111; bus.req0_amt = 2'd1; bus.req0_dir = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m_last  = 1'b1;
    m_count = 0;
    #1;
    n_tests++;
    if ({busy, bus.rsp_valid, op_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b valid=%b count=%0d expected 0 0 0", busy, bus.rsp_valid, op_count);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_rsp: rsp_valid=%b expected 0 at cycle %0d", bus.rsp_valid, k);
      end
    end
    run_op(1'b1, 1'b1, 4'b0010, 4'b0100, 2'd1, 2'd1, 1'b0, 1'b0, 0, id, d);
    n_tests++;
    if (id !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_last_grant: granted %b expected 0", id);
    end
  endtask

  task automatic test_random();
    bit         id;
    logic [3:0] d;
    int         pat;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        n_tests++;
        if ({busy, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
          n_fail++;
          $display("FAIL idle_ready: busy,ready=%b expected 000", {busy, bus.req1_ready, bus.req0_ready});
        end
      end
      pat = $urandom_range(1, 3);
      run_op(pat[0], pat[1], 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 2), id, d);
    end
  endtask

  initial begin
    idle_inputs();
    rst     = 1'b1;
    m_last  = 1'b1;
    m_count = 0;
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
